// File: rtl/seg_scan_pkg.sv
// Shared types and constants for the seven-segment scan controller.
package seg_scan_pkg;

    typedef enum logic {BLANK = 1'b0, DRIVE = 1'b1} scan_state_t;

    localparam logic [6:0] SEG_BLANK        = 7'b1111111;
    localparam int         DEF_DIGITS       = 4;
    localparam int         DEF_SLOT_CYCLES  = 50000;
    localparam int         DEF_BLANK_CYCLES = 2;
    localparam int         MAX_DIGITS       = 32;

    // All-anodes-off pattern for a display of the given width (low bits set).
    function automatic logic [MAX_DIGITS-1:0] an_off(input int digits);
        logic [MAX_DIGITS-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            m[i] = (i < digits);
        end
        return m;
    endfunction

endpackage

// File: rtl/seg_scan_ctrl_timer.sv
// Phase counter for one digit slot; tc pulses on the last cycle of the current phase.
module scan_timer
    import seg_scan_pkg::*;
#(
    parameter int SLOT_CYCLES  = DEF_SLOT_CYCLES,
    parameter int BLANK_CYCLES = DEF_BLANK_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  scan_state_t phase,
    output logic        tc
);

    localparam int            TW         = $clog2(SLOT_CYCLES + 1);
    localparam logic [TW-1:0] BLANK_LAST = TW'(BLANK_CYCLES - 1);
    localparam logic [TW-1:0] DRIVE_LAST = TW'(SLOT_CYCLES - BLANK_CYCLES - 1);

    logic [TW-1:0] count;

    // Terminal count depends on which phase is being timed.
    always_comb begin
        tc = 1'b0;
        case (phase)
            BLANK:   tc = (count == BLANK_LAST);
            DRIVE:   tc = (count == DRIVE_LAST);
            default: tc = 1'b0;
        endcase
    end

    // Counter restarts at every phase change.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (tc) begin
            count <= '0;
        end else begin
            count <= count + TW'(1);
        end
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed seven-segment scan controller with a double-buffered load port
// and a shared external hex decoder.
module seg_scan_ctrl
    import seg_scan_pkg::*;
#(
    parameter int DIGITS       = DEF_DIGITS,
    parameter int SLOT_CYCLES  = DEF_SLOT_CYCLES,
    parameter int BLANK_CYCLES = DEF_BLANK_CYCLES
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic [4*DIGITS-1:0]   load_value,
    input  logic [DIGITS-1:0]     load_dp,
    input  logic                  lzb_en,
    output logic [3:0]            dec_in,
    input  logic [6:0]            dec_out,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     an
);

    localparam int                     IW         = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [MAX_DIGITS-1:0]  AN_OFF_ALL = an_off(DIGITS);
    localparam logic [DIGITS-1:0]      AN_OFF     = AN_OFF_ALL[DIGITS-1:0];
    localparam logic [IW-1:0]          LAST_IDX   = IW'(DIGITS - 1);

    scan_state_t          state;
    logic [IW-1:0]        idx;
    logic [4*DIGITS-1:0]  active_value;
    logic [4*DIGITS-1:0]  pending_value;
    logic [DIGITS-1:0]    active_dp;
    logic [DIGITS-1:0]    pending_dp;
    logic                 pending_full;
    logic                 tc;
    logic                 accept;
    logic                 blank_digit;
    logic [4*DIGITS-1:0]  higher;
    logic [DIGITS-1:0]    drive_an;

    scan_timer #(
        .SLOT_CYCLES  (SLOT_CYCLES),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_timer (
        .clk   (clk),
        .reset (reset),
        .phase (state),
        .tc    (tc)
    );

    assign accept = load_valid && load_ready;
    assign dec_in = active_value[idx*4 +: 4];

    // Leading-zero test covers the current nibble and everything above it.
    always_comb begin
        higher   = active_value >> {idx, 2'b00};
        drive_an = AN_OFF;
        drive_an[idx] = 1'b0;
        if (lzb_en && (idx != '0) && (higher == '0)) begin
            blank_digit = 1'b1;
        end else begin
            blank_digit = 1'b0;
        end
    end

    // Slot FSM, load buffer and registered display outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= BLANK;
            idx           <= '0;
            an            <= AN_OFF;
            seg           <= SEG_BLANK;
            dp            <= 1'b1;
            active_value  <= '0;
            active_dp     <= '0;
            pending_value <= '0;
            pending_dp    <= '0;
            pending_full  <= 1'b0;
            load_ready    <= 1'b1;
        end else begin
            if (accept) begin
                pending_value <= load_value;
                pending_dp    <= load_dp;
                pending_full  <= 1'b1;
                load_ready    <= 1'b0;
            end
            case (state)
                BLANK: begin
                    if (tc) begin
                        state <= DRIVE;
                        an    <= drive_an;
                        seg   <= blank_digit ? SEG_BLANK : dec_out;
                        dp    <= ~active_dp[idx];
                    end
                end
                DRIVE: begin
                    if (tc) begin
                        state <= BLANK;
                        an    <= AN_OFF;
                        seg   <= SEG_BLANK;
                        dp    <= 1'b1;
                        if (idx == LAST_IDX) begin
                            idx <= '0;
                            // Frame boundary: pending_full implies no accept this cycle.
                            if (pending_full) begin
                                active_value <= pending_value;
                                active_dp    <= pending_dp;
                                pending_full <= 1'b0;
                                load_ready   <= 1'b1;
                            end
                        end else begin
                            idx <= idx + IW'(1);
                        end
                    end
                end
                default: begin
                    state <= BLANK;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Randomized bench for seg_scan_ctrl, checked every cycle against a time-indexed display model.
module tb_seg_scan_ctrl;

    localparam int DIGITS = 4;
    localparam int SLOT   = 8;
    localparam int BLANK  = 2;
    localparam int FRAME  = DIGITS * SLOT;
    localparam int NCYC   = 4000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load_valid = 1'b0;
    logic        load_ready;
    logic [15:0] load_value = 16'h0000;
    logic [3:0]  load_dp = 4'h0;
    logic        lzb_en = 1'b0;
    logic [3:0]  dec_in;
    logic [6:0]  dec_out;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

    function automatic logic [6:0] hex7(input logic [3:0] h);
        case (h)
            4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;  4'hF: return 7'b0001110;
            default: return 7'b1111111;
        endcase
    endfunction

    assign dec_out = hex7(dec_in);

    seg_scan_ctrl #(
        .DIGITS       (DIGITS),
        .SLOT_CYCLES  (SLOT),
        .BLANK_CYCLES (BLANK)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_value (load_value),
        .load_dp    (load_dp),
        .lzb_en     (lzb_en),
        .dec_in     (dec_in),
        .dec_out    (dec_out),
        .seg        (seg),
        .dp         (dp),
        .an         (an)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    // Model state: cycles since reset, displayed value, and one-deep pending buffer.
    int          k = 0;
    logic [15:0] m_active = 16'h0000;
    logic [3:0]  m_adp = 4'h0;
    logic [15:0] m_pending = 16'h0000;
    logic [3:0]  m_pdp = 4'h0;
    bit          m_pend = 1'b0;
    bit          m_lzb = 1'b0;

    logic [15:0] dir_val [4] = '{16'h1234, 16'hAAAA, 16'h5555, 16'h0040};
    logic [3:0]  dir_dp  [4] = '{4'b0000, 4'b0000, 4'b0000, 4'b0001};
    int          dir_i = 0;
    int          n_resets = 0;

    initial begin
        int          pos, digit;
        bit          boundary, take, blanked;
        logic [15:0] upper, rv;
        logic [6:0]  e_seg;
        logic        e_dp;
        logic [3:0]  e_an;

        for (cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge clk);
            pos   = k % SLOT;
            digit = (k / SLOT) % DIGITS;

            e_an = (pos < BLANK) ? 4'hF : ~(4'b0001 << digit);
            upper = m_active >> (4 * digit);
            blanked = m_lzb && (digit != 0) && (upper == 16'h0000);
            if (pos < BLANK) begin
                e_seg = 7'b1111111;
                e_dp  = 1'b1;
            end else begin
                e_seg = blanked ? 7'b1111111 : hex7(upper[3:0]);
                e_dp  = ~m_adp[digit];
            end
            check_eq("an", 32'(an), 32'(e_an));
            check_eq("seg", 32'(seg), 32'(e_seg));
            check_eq("dp", 32'(dp), 32'(e_dp));
            check_eq("dec_in", 32'(dec_in), 32'(upper[3:0]));
            check_eq("load_ready", 32'(load_ready), 32'(!m_pend));

            // Inputs for this cycle.
            reset = (cyc < 3) ||
                    (m_pend && digit == 2 && pos == BLANK + 1 && n_resets < 4 &&
                     $urandom_range(0, 1) == 0);
            if (reset && cyc >= 3) n_resets++;
            if (((cyc / 256) % 2) == 1) load_valid = 1'b1;
            else load_valid = ($urandom_range(0, 7) == 0);
            if (dir_i < 4) begin
                load_value = dir_val[dir_i];
                load_dp    = dir_dp[dir_i];
                lzb_en     = (dir_i == 3);
            end else begin
                for (int n = 0; n < 4; n++) begin
                    rv[4*n +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
                end
                load_value = rv;
                load_dp    = 4'($urandom_range(0, 15));
                if ($urandom_range(0, 40) == 0) lzb_en = ~lzb_en;
            end

            // Apply the clock edge to the model.
            if (reset) begin
                k = 0;
                m_active = 16'h0000;
                m_adp = 4'h0;
                m_pend = 1'b0;
            end else begin
                boundary = ((k % FRAME) == FRAME - 1);
                take = load_valid && !m_pend;
                if (pos == BLANK - 1) m_lzb = lzb_en;
                if (boundary && m_pend) begin
                    m_active = m_pending;
                    m_adp    = m_pdp;
                    m_pend   = 1'b0;
                end
                if (take) begin
                    m_pending = load_value;
                    m_pdp     = load_dp;
                    m_pend    = 1'b1;
                    if (dir_i < 4) dir_i++;
                end
                k++;
            end
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
